// File: rtl/rob_wide_if.sv
// Bundle of all non-clock ROB signals; slave is the ROB side, master is the front-end/back-end side.
// Alloc lane k transfers on a rising edge when alloc_valid_i[0..k] are all high and alloc_ready_o is high; wb and commit are valid-only strobes with no backpressure.
interface rob_if #(
   parameter int DEPTH    = 16,
   parameter int ALLOC_W  = 2,
   parameter int COMMIT_W = 2
);
   localparam int IDX_W = $clog2(DEPTH);

   logic                            flush_i;
   logic [ALLOC_W-1:0]              alloc_valid_i;
   logic [ALLOC_W-1:0][31:0]        alloc_pc_i;
   logic [ALLOC_W-1:0][4:0]         alloc_rd_i;
   logic [ALLOC_W-1:0]              alloc_we_i;
   logic                            alloc_ready_o;
   logic [ALLOC_W-1:0][IDX_W-1:0]   alloc_idx_o;
   logic                            wb_valid_i;
   logic [IDX_W-1:0]                wb_idx_i;
   logic [31:0]                     wb_result_i;
   logic [31:0]                     wb_new_pc_i;
   logic                            wb_redirect_i;
   logic                            wb_xcpt_i;
   logic [COMMIT_W-1:0]             commit_valid_o;
   logic [COMMIT_W-1:0][31:0]       commit_pc_o;
   logic [COMMIT_W-1:0][4:0]        commit_rd_o;
   logic [COMMIT_W-1:0][31:0]       commit_result_o;
   logic [COMMIT_W-1:0]             commit_we_o;
   logic                            commit_redirect_o;
   logic                            commit_xcpt_o;
   logic [31:0]                     commit_new_pc_o;
   logic [IDX_W:0]                  count_o;
   logic [4:0]                      lookup_rs_i;
   logic                            lookup_hit_o;
   logic [IDX_W-1:0]                lookup_idx_o;
   logic                            lookup_done_o;
   logic [31:0]                     lookup_result_o;

   modport slave (
      input  flush_i, alloc_valid_i, alloc_pc_i, alloc_rd_i, alloc_we_i,
      input  wb_valid_i, wb_idx_i, wb_result_i, wb_new_pc_i, wb_redirect_i, wb_xcpt_i,
      input  lookup_rs_i,
      output alloc_ready_o, alloc_idx_o,
      output commit_valid_o, commit_pc_o, commit_rd_o, commit_result_o, commit_we_o,
      output commit_redirect_o, commit_xcpt_o, commit_new_pc_o, count_o,
      output lookup_hit_o, lookup_idx_o, lookup_done_o, lookup_result_o
   );

   modport master (
      output flush_i, alloc_valid_i, alloc_pc_i, alloc_rd_i, alloc_we_i,
      output wb_valid_i, wb_idx_i, wb_result_i, wb_new_pc_i, wb_redirect_i, wb_xcpt_i,
      output lookup_rs_i,
      input  alloc_ready_o, alloc_idx_o,
      input  commit_valid_o, commit_pc_o, commit_rd_o, commit_result_o, commit_we_o,
      input  commit_redirect_o, commit_xcpt_o, commit_new_pc_o, count_o,
      input  lookup_hit_o, lookup_idx_o, lookup_done_o, lookup_result_o
   );
endinterface

// File: rtl/rob_wide.sv
// Multi-lane reorder buffer: in-order allocate, out-of-order writeback, in-order multi-lane commit.
// A retiring redirect (or flush_i) empties the whole buffer.
module rob_wide #(
   parameter int DEPTH    = 16,
   parameter int ALLOC_W  = 2,
   parameter int COMMIT_W = 2
) (
   input  logic  clk_i,
   input  logic  rstn_i,
   rob_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [DEPTH-1:0]              r_valid, r_done, r_we, r_redir, r_xcpt;
   logic [DEPTH-1:0][31:0]        r_pc, r_result, r_new_pc;
   logic [DEPTH-1:0][4:0]         r_rd;
   logic [IDX_W-1:0]              r_head, r_tail;
   logic [CNT_W-1:0]              r_count;

   logic                          w_ready, w_clear, w_redir_ret, w_alloc_run, w_commit_run;
   logic [CNT_W-1:0]              w_alloc_n, w_commit_n;
   logic [COMMIT_W-1:0]           w_fire, w_show;
   logic [COMMIT_W-1:0][IDX_W-1:0] w_cidx;
   logic [IDX_W-1:0]              w_lidx;

   assign w_ready           = (r_count <= CNT_W'(DEPTH - ALLOC_W));
   assign bus.alloc_ready_o = w_ready;
   assign bus.count_o       = r_count;
   assign w_clear           = bus.flush_i | w_redir_ret;
   assign w_show            = w_fire & ~{COMMIT_W{bus.flush_i}};

   always_comb begin
      bus.alloc_idx_o = '0;
      for (int k = 0; k < ALLOC_W; k++) bus.alloc_idx_o[k] = r_tail + IDX_W'(k);
   end

   // Lanes count only while contiguous from lane 0; nothing is taken when full or clearing.
   always_comb begin
      w_alloc_n   = '0;
      w_alloc_run = 1'b1;
      for (int k = 0; k < ALLOC_W; k++) begin
         if (w_alloc_run && bus.alloc_valid_i[k]) w_alloc_n = w_alloc_n + CNT_W'(1);
         else w_alloc_run = 1'b0;
      end
      if (!w_ready || w_clear) w_alloc_n = '0;
   end

   // A redirect entry stops the scan so it is always the last lane retired this cycle.
   always_comb begin
      w_fire       = '0;
      w_cidx       = '0;
      w_commit_n   = '0;
      w_redir_ret  = 1'b0;
      w_commit_run = 1'b1;
      for (int j = 0; j < COMMIT_W; j++) begin
         w_cidx[j] = r_head + IDX_W'(j);
         if (w_commit_run && r_valid[w_cidx[j]] && r_done[w_cidx[j]]) begin
            w_fire[j]  = 1'b1;
            w_commit_n = w_commit_n + CNT_W'(1);
            if (r_redir[w_cidx[j]]) begin
               w_redir_ret  = 1'b1;
               w_commit_run = 1'b0;
            end
         end else begin
            w_commit_run = 1'b0;
         end
      end
   end

   always_comb begin
      bus.commit_valid_o    = '0;
      bus.commit_pc_o       = '0;
      bus.commit_rd_o       = '0;
      bus.commit_result_o   = '0;
      bus.commit_we_o       = '0;
      bus.commit_redirect_o = 1'b0;
      bus.commit_xcpt_o     = 1'b0;
      bus.commit_new_pc_o   = '0;
      for (int j = 0; j < COMMIT_W; j++) begin
         if (w_show[j]) begin
            bus.commit_valid_o[j]  = 1'b1;
            bus.commit_pc_o[j]     = r_pc[w_cidx[j]];
            bus.commit_rd_o[j]     = r_rd[w_cidx[j]];
            bus.commit_result_o[j] = r_result[w_cidx[j]];
            bus.commit_we_o[j]     = r_we[w_cidx[j]];
            bus.commit_redirect_o  = r_redir[w_cidx[j]];
            bus.commit_xcpt_o      = r_xcpt[w_cidx[j]];
            bus.commit_new_pc_o    = r_new_pc[w_cidx[j]];
         end
      end
   end

   // Oldest-to-youngest scan; the last match overwrites earlier ones, so the youngest wins.
   always_comb begin
      bus.lookup_hit_o    = 1'b0;
      bus.lookup_idx_o    = '0;
      bus.lookup_done_o   = 1'b0;
      bus.lookup_result_o = '0;
      w_lidx              = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_lidx = r_head + IDX_W'(k);
         if ((CNT_W'(k) < r_count) && r_valid[w_lidx] && r_we[w_lidx] &&
             (r_rd[w_lidx] == bus.lookup_rs_i) && (bus.lookup_rs_i != 5'd0)) begin
            bus.lookup_hit_o    = 1'b1;
            bus.lookup_idx_o    = w_lidx;
            bus.lookup_done_o   = r_done[w_lidx];
            bus.lookup_result_o = r_result[w_lidx];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_valid  <= '0;
         r_done   <= '0;
         r_we     <= '0;
         r_redir  <= '0;
         r_xcpt   <= '0;
         r_pc     <= '0;
         r_result <= '0;
         r_new_pc <= '0;
         r_rd     <= '0;
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
      end else if (w_clear) begin
         r_valid <= '0;
         r_done  <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (bus.wb_valid_i && r_valid[bus.wb_idx_i]) begin
            r_done[bus.wb_idx_i]   <= 1'b1;
            r_result[bus.wb_idx_i] <= bus.wb_result_i;
            r_new_pc[bus.wb_idx_i] <= bus.wb_new_pc_i;
            r_redir[bus.wb_idx_i]  <= bus.wb_redirect_i | bus.wb_xcpt_i;
            r_xcpt[bus.wb_idx_i]   <= bus.wb_xcpt_i;
         end
         for (int j = 0; j < COMMIT_W; j++) begin
            if (w_fire[j]) begin
               r_valid[w_cidx[j]] <= 1'b0;
               r_done[w_cidx[j]]  <= 1'b0;
            end
         end
         for (int k = 0; k < ALLOC_W; k++) begin
            if (CNT_W'(k) < w_alloc_n) begin
               r_valid[bus.alloc_idx_o[k]]  <= 1'b1;
               r_done[bus.alloc_idx_o[k]]   <= 1'b0;
               r_redir[bus.alloc_idx_o[k]]  <= 1'b0;
               r_xcpt[bus.alloc_idx_o[k]]   <= 1'b0;
               r_result[bus.alloc_idx_o[k]] <= '0;
               r_new_pc[bus.alloc_idx_o[k]] <= '0;
               r_pc[bus.alloc_idx_o[k]]     <= bus.alloc_pc_i[k];
               r_rd[bus.alloc_idx_o[k]]     <= bus.alloc_rd_i[k];
               r_we[bus.alloc_idx_o[k]]     <= bus.alloc_we_i[k];
            end
         end
         r_head  <= r_head + w_commit_n[IDX_W-1:0];
         r_tail  <= r_tail + w_alloc_n[IDX_W-1:0];
         r_count <= r_count + w_alloc_n - w_commit_n;
      end
   end
endmodule

// File: doc/rob_wide.md
ROB_WIDE -- requirements
Module: rob_wide

Interface
REQ-001 SHALL have parameter DEPTH, default 16, ROB entries (power of two, >=4).
REQ-002 SHALL have parameter ALLOC_W, default 2, allocation lanes per cycle (1..4, <=DEPTH).
REQ-003 SHALL have parameter COMMIT_W, default 2, commit lanes per cycle (1..4, <=DEPTH).
REQ-004 SHALL define IDX_W = log2(DEPTH) as the entry-index width.
REQ-005 clk_i  in  1  clock; the block has one clock and all state updates on its rising edge.
REQ-006 rstn_i  in  1  reset; asynchronous and active-low.
REQ-007 flush_i  in  1  discard all entries.
REQ-008 alloc_valid_i  in  ALLOC_W  per-lane allocate request.
REQ-009 alloc_pc_i  in  ALLOC_W x 32  per-lane PC.
REQ-010 alloc_rd_i  in  ALLOC_W x 5  per-lane destination register.
REQ-011 alloc_we_i  in  ALLOC_W  per-lane register write enable.
REQ-012 alloc_ready_o  out  1  at least ALLOC_W entries are free.
REQ-013 alloc_idx_o  out  ALLOC_W x IDX_W  index given to each lane.
REQ-014 wb_valid_i, wb_idx_i, wb_result_i, wb_new_pc_i, wb_redirect_i, wb_xcpt_i  in  1/IDX_W/32/32/1/1  completion of one entry.
REQ-015 commit_valid_o  out  COMMIT_W  per-lane retire strobe.
REQ-016 commit_pc_o, commit_rd_o, commit_result_o, commit_we_o  out  COMMIT_W x (32/5/32/1)  retired entry fields.
REQ-017 commit_redirect_o, commit_xcpt_o, commit_new_pc_o  out  1/1/32  redirect raised by the last retired lane.
REQ-018 count_o  out  IDX_W+1  occupancy.
REQ-019 lookup_rs_i  in  5  source register; lookup_hit_o, lookup_idx_o, lookup_done_o, lookup_result_o  out  1/IDX_W/1/32  hazard result.

Function
REQ-020 Allocation SHALL use a contiguous mask: lanes above the first deasserted lane are ignored.
REQ-021 alloc_idx_o[k] SHALL equal (tail+k) mod DEPTH, combinational from registered tail.
REQ-022 Allocation SHALL occur only when alloc_ready_o=1; alloc_ready_o = (DEPTH-count_o >= ALLOC_W). When alloc_ready_o=0, requests SHALL be dropped with no state change.
REQ-023 An allocated entry SHALL become valid and not completed, with wrap-around of tail modulo DEPTH.
REQ-024 A writeback to an invalid entry SHALL be ignored. A writeback to a valid entry SHALL set completed, result, new_pc, redirect=wb_redirect_i|wb_xcpt_i and xcpt; these fields become visible the next cycle.
REQ-025 Commit lane j SHALL fire iff lanes 0..j-1 fired, entry (head+j) mod DEPTH is valid and completed, and no lower lane retired a redirect entry. A redirect entry therefore retires as the last lane of its cycle.
REQ-026 Retired entries SHALL be invalidated; head advances by the number of fired lanes.
REQ-027 count_o next SHALL equal count + allocated - committed.
REQ-028 If a retired entry has redirect=1, or flush_i=1: all entries SHALL be invalidated, head=tail=count=0 next cycle, and same-cycle allocations dropped. Commit outputs for that cycle SHALL still be presented, except under flush_i, which masks commit_valid_o to 0.
REQ-029 commit_redirect_o, commit_xcpt_o and commit_new_pc_o SHALL come from the highest fired lane; they are 0 when no lane fires.
REQ-030 Unfired commit lanes SHALL drive all-zero fields.
REQ-031 Lookup SHALL select the youngest valid entry (search from tail-1 back to head) with rd==lookup_rs_i, we=1 and rd!=0. It SHALL report hit, idx, completed and result from registered state only. A miss SHALL drive all-zero outputs.

Reset
REQ-032 While rstn_i=0: head, tail and count = 0; all entries invalid and not completed; commit outputs = 0; lookup outputs = 0; alloc_ready_o = 1.
REQ-033 Assertion of reset mid-operation SHALL discard all in-flight entries immediately, without waiting for a clock edge.

Verification (DEPTH=8, ALLOC_W=2, COMMIT_W=2)
REQ-034 Alloc 2/cycle for 3 cycles, no wb -> idx 0,1 / 2,3 / 4,5; count_o=6; alloc_ready_o=1; then count_o=8 after a 4th alloc and alloc_ready_o=0.
REQ-035 wb idx1 then idx0 -> no commit after idx1 wb; the cycle after idx0 wb, both lanes commit 0,1; count_o drops by 2.
REQ-036 Fill, retire and refill across entry 7 -> indices wrap 7,0; commit order preserved.
REQ-037 Entries 0..3 valid, 0 and 1 completed, entry 0 redirect, new_pc 0x80 -> lane0 only; commit_redirect_o=1, commit_new_pc_o=0x80; next cycle count_o=0; same-cycle alloc dropped.
REQ-038 rd x5 allocated at idx2 and idx4; lookup x5 -> hit, idx=4. Lookup x0 -> no hit.
REQ-039 flush_i with 5 entries, then rstn_i pulse mid-fill -> count_o=0, commit_valid_o=0, alloc_ready_o=1.
